// File: rtl/mmu_tlb_if.sv
// mmu_tlb_if: groups the request/response signals of mmu_tlb.
//   master : control and lookup source (drives requests, receives results)
//   slave  : the TLB itself
// Request signals : stall, mmu_en, mmu_update, tlb_wr, wr_vpage, wr_ppage,
//                   tlb_flush, vaddr_in, lookup_valid
// Result signals  : paddr_o, mmu_error_o, hit_idx_o, miss_cnt_o
interface mmu_tlb_if #(
    parameter int PAGE_NUM_WIDTH = 20,
    parameter int ENTRIES        = 4
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic                      stall;
    logic                      mmu_en;
    logic                      mmu_update;
    logic                      tlb_wr;
    logic [PAGE_NUM_WIDTH-1:0] wr_vpage;
    logic [PAGE_NUM_WIDTH-1:0] wr_ppage;
    logic                      tlb_flush;
    logic [31:0]               vaddr_in;
    logic                      lookup_valid;
    logic [31:0]               paddr_o;
    logic                      mmu_error_o;
    logic [IDX_W-1:0]          hit_idx_o;
    logic [15:0]               miss_cnt_o;

    modport master (
        output stall, mmu_en, mmu_update, tlb_wr, wr_vpage, wr_ppage,
               tlb_flush, vaddr_in, lookup_valid,
        input  paddr_o, mmu_error_o, hit_idx_o, miss_cnt_o
    );

    modport slave (
        input  stall, mmu_en, mmu_update, tlb_wr, wr_vpage, wr_ppage,
               tlb_flush, vaddr_in, lookup_valid,
        output paddr_o, mmu_error_o, hit_idx_o, miss_cnt_o
    );
endinterface

// File: rtl/mmu_tlb.sv
// mmu_tlb: fully associative, zero-latency TLB for 4 KB pages.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - mmu_tlb_if.slave: write/flush/enable controls, lookup address,
//           translated address, miss flag, hit index and miss counter
// Optional feature: define MMU_TLB_MISS_CNT_EN to build the saturating miss
// counter; otherwise miss_cnt_o is tied to zero.
module mmu_tlb #(
    parameter int PAGE_NUM_WIDTH = 20,
    parameter int ENTRIES        = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    mmu_tlb_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OFF_W = 32 - PAGE_NUM_WIDTH;

    logic [ENTRIES-1:0]        valid_q, valid_d;
    logic [PAGE_NUM_WIDTH-1:0] vpage_q [ENTRIES];
    logic [PAGE_NUM_WIDTH-1:0] vpage_d [ENTRIES];
    logic [PAGE_NUM_WIDTH-1:0] ppage_q [ENTRIES];
    logic [PAGE_NUM_WIDTH-1:0] ppage_d [ENTRIES];
    logic [IDX_W-1:0]          vptr_q, vptr_d;
    logic                      mmu_en_q, mmu_en_d;

    logic                      wr_act, fl_act, en;
    logic [PAGE_NUM_WIDTH-1:0] lk_vpage;
    logic [ENTRIES-1:0]        valid_eff;
    logic                      dup_hit, free_found;
    logic [IDX_W-1:0]          dup_idx, free_idx, vptr_base, wr_idx;
    logic                      st_hit, byp_hit, hit;
    logic [IDX_W-1:0]          st_idx;
    logic [PAGE_NUM_WIDTH-1:0] hit_ppage;
    logic [31:0]               paddr;
    logic                      err;
    logic [IDX_W-1:0]          hit_idx;

    assign wr_act   = bus.tlb_wr & ~bus.stall;
    assign fl_act   = bus.tlb_flush & ~bus.stall;
    assign en       = bus.mmu_update ? bus.mmu_en : mmu_en_q;
    assign lk_vpage = bus.vaddr_in[31 -: PAGE_NUM_WIDTH];

    // Write-side view of the valid bits: a concurrent flush is applied
    // before the write chooses its slot.
    assign valid_eff = fl_act ? '0 : valid_q;
    assign vptr_base = fl_act ? '0 : vptr_q;

    // Duplicate detection and lowest free slot, both lowest-index first.
    always_comb begin
        dup_hit    = 1'b0;
        dup_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!dup_hit && valid_eff[i] && vpage_q[i] == bus.wr_vpage) begin
                dup_hit = 1'b1;
                dup_idx = IDX_W'(i);
            end
            if (!free_found && !valid_eff[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        if (dup_hit)         wr_idx = dup_idx;
        else if (free_found) wr_idx = free_idx;
        else                 wr_idx = vptr_base;
    end

    // Stored lookup sees the entries as they are this cycle; lowest index wins.
    always_comb begin
        st_hit = 1'b0;
        st_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!st_hit && valid_q[i] && vpage_q[i] == lk_vpage) begin
                st_hit = 1'b1;
                st_idx = IDX_W'(i);
            end
        end
    end

    // A write in flight overrides stored data for its own vpage, reporting
    // the slot it is about to occupy.
    assign byp_hit   = wr_act && (bus.wr_vpage == lk_vpage);
    assign hit       = byp_hit | st_hit;
    assign hit_ppage = byp_hit ? bus.wr_ppage : ppage_q[st_idx];

    always_comb begin
        paddr   = bus.vaddr_in;
        err     = 1'b0;
        hit_idx = '0;
        if (en) begin
            if (hit) begin
                paddr   = {hit_ppage, bus.vaddr_in[OFF_W-1:0]};
                hit_idx = byp_hit ? wr_idx : st_idx;
            end else begin
                err = 1'b1;
            end
        end
    end

    assign bus.paddr_o     = paddr;
    assign bus.mmu_error_o = err;
    assign bus.hit_idx_o   = hit_idx;

    always_comb begin
        valid_d  = valid_eff;
        vpage_d  = vpage_q;
        ppage_d  = ppage_q;
        vptr_d   = vptr_base;
        mmu_en_d = mmu_en_q;
        if (wr_act) begin
            valid_d[wr_idx] = 1'b1;
            vpage_d[wr_idx] = bus.wr_vpage;
            ppage_d[wr_idx] = bus.wr_ppage;
            if (!dup_hit) begin
                vptr_d = vptr_base + 1'b1;
            end
        end
        if (bus.mmu_update && !bus.stall) begin
            mmu_en_d = bus.mmu_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= '0;
            vptr_q   <= '0;
            mmu_en_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            vptr_q   <= vptr_d;
            mmu_en_q <= mmu_en_d;
        end
    end

    // Page data needs no reset: it is qualified by the valid bits.
    always_ff @(posedge clk) begin
        vpage_q <= vpage_d;
        ppage_q <= ppage_d;
    end

`ifdef MMU_TLB_MISS_CNT_EN
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (bus.lookup_valid && err && !bus.stall && miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) miss_cnt_q <= '0;
        else        miss_cnt_q <= miss_cnt_d;
    end

    assign bus.miss_cnt_o = miss_cnt_q;
`else
    logic unused_lookup_valid;
    assign unused_lookup_valid = bus.lookup_valid;
    assign bus.miss_cnt_o      = '0;
`endif
endmodule
